alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issues add/sub commands to a no-backpressure ALU and queues its results for downstream.
// Latency: command accepted at edge N -> result visible on res_data after edge N+2.
// Backpressure: cmd_ready is credit-gated (fifo_count + inflight < DEPTH), so no result is ever dropped.

module alu_issue_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_rdy,
    output logic                         head_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_vld;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign pop_vld  = pop_rdy && head_vld;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [WIDTH-1:0]             cmd_a,
    input  logic [WIDTH-1:0]             cmd_b,
    input  logic                         cmd_op,
    output logic [WIDTH-1:0]             alu_a,
    output logic [WIDTH-1:0]             alu_b,
    output logic                         alu_op,
    output logic                         alu_valid,
    input  logic [WIDTH-1:0]             alu_result,
    input  logic                         alu_result_valid,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH-1:0]             res_data,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         stray_err
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_cmd_t;

    alu_cmd_t      issue_dat;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;
    logic          cmd_acc;
    logic          ret_vld;

    // Credits count both queued results and results still inside the ALU.
    assign occ       = {1'b0, fifo_count} + {1'b0, inflight};
    assign cmd_ready = resetn && (occ < (CW+1)'(DEPTH));
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign ret_vld   = alu_result_valid && (inflight != '0);

    assign alu_a  = issue_dat.a;
    assign alu_b  = issue_dat.b;
    assign alu_op = issue_dat.op;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            issue_dat <= '0;
            alu_valid <= 1'b0;
            inflight  <= '0;
            stray_err <= 1'b0;
        end else begin
            alu_valid <= cmd_acc;
            if (cmd_acc) begin
                issue_dat <= '{op: cmd_op, a: cmd_a, b: cmd_b};
            end
            case ({cmd_acc, ret_vld})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            // A result with nothing outstanding cannot be matched to a command.
            if (alu_result_valid && (inflight == '0)) begin
                stray_err <= 1'b1;
            end
        end
    end

    alu_issue_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (ret_vld),
        .push_dat (alu_result),
        .pop_rdy  (res_ready),
        .head_vld (res_valid),
        .head_dat (res_data),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-register add/sub ALU model in the loop.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic        cmd_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_op, alu_valid;
    logic [31:0] alu_result;
    logic        alu_result_valid;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  inflight;
    logic        stray_err;

    logic [31:0] alu_res_q;
    logic        alu_rv_q;
    logic        inj_rv;
    logic [31:0] inj_val;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .inflight(inflight), .stray_err(stray_err)
    );

    // ALU: inputs captured at one edge, result valid for the following edge.
    always @(posedge clk) begin
        alu_rv_q  <= alu_valid;
        alu_res_q <= alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
    end
    assign alu_result_valid = alu_rv_q | inj_rv;
    assign alu_result       = inj_rv ? inj_val : alu_res_q;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic op);
        return op ? (a - b) : (a + b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=unexpected result %0h expected=none", tag, res_data);
        end else begin
            chk(tag, res_data, q.pop_front());
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        if (cmd_ready) q.push_back(alu_f(a, b, op));
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            if (res_valid) pop_check(tag);
            step();
        end
        chk({tag, "_empty"}, q.size(), 0);
        chk({tag, "_res_valid"}, res_valid, 0);
    endtask

    initial begin
        int acc, rx, cycles;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 1'b0;
        res_ready = 1'b0; inj_rv = 1'b0; inj_val = '0;
        step(); step();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_stray", stray_err, 0);
        resetn = 1'b1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Single add 5+3
        issue(32'd5, 32'd3, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("add_alu_valid", alu_valid, 1);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 3);
        chk("add_alu_op", alu_op, 0);
        chk("add_inflight1", inflight, 1);
        chk("add_res_valid_early", res_valid, 0);
        step();
        chk("add_alu_valid_drop", alu_valid, 0);
        chk("add_alu_a_hold", alu_a, 5);
        chk("add_inflight_mid", inflight, 1);
        chk("add_res_valid_mid", res_valid, 0);
        step();
        chk("add_res_valid", res_valid, 1);
        chk("add_res_data", res_data, 8);
        chk("add_inflight0", inflight, 0);
        drain("add_drain");

        // Single sub with wrap 0-1
        res_ready = 1'b0;
        issue(32'd0, 32'd1, 1'b1);
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("sub_res_valid", res_valid, 1);
        chk("sub_res_data", res_data, 32'hFFFF_FFFF);
        drain("sub_drain");

        // Backpressure: 6 back-to-back commands, nothing drained
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) chk("bp_rdy_low", cmd_ready, 0);
            if (cmd_ready) acc++;
            issue(32'(i * 10 + 1), 32'(i), i[0]);
            step();
        end
        cmd_valid = 1'b0;
        step();
        chk("bp_accepted", acc, 4);
        chk("bp_cmd_ready_full", cmd_ready, 0);
        chk("bp_inflight", inflight, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_head_val", res_data, 1);
        res_ready = 1'b1;
        pop_check("bp_head");
        step();
        res_ready = 1'b0;
        chk("bp_rdy_back", cmd_ready, 1);
        chk("bp_next_head", res_data, 10);
        drain("bp_drain");

        // Streaming 100 random commands with res_ready high
        res_ready = 1'b1;
        rx = 0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid) begin pop_check("stream_data"); rx++; end
            chk("stream_rdy", cmd_ready, 1);
            issue($urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
            cycles++;
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            if (res_valid) begin pop_check("stream_data"); rx++; end
            step();
            cycles++;
        end
        chk("stream_rx", rx, 100);
        chk("stream_rate", (cycles <= 104), 1);

        // Full FIFO with res_ready toggling
        for (int i = 0; i < 60; i++) begin
            res_ready = (i < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            if (res_valid && res_ready) pop_check("tog_data");
            issue($urandom, $urandom, 1'($urandom_range(0, 1)));
            chk("tog_occ_le_depth", (q.size() <= 4), 1);
            step();
        end
        cmd_valid = 1'b0;
        drain("tog_drain");

        // Stray return while one result sits in the FIFO
        res_ready = 1'b0;
        issue(32'd7, 32'd2, 1'b0);
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("stray_pre_flag", stray_err, 0);
        inj_rv = 1'b1; inj_val = 32'hDEAD_BEEF;
        step();
        inj_rv = 1'b0;
        chk("stray_flag", stray_err, 1);
        chk("stray_fifo_head", res_data, 9);
        chk("stray_inflight", inflight, 0);
        drain("stray_drain");
        step();
        chk("stray_sticky", stray_err, 1);

        // Reset with two commands in flight
        res_ready = 1'b0;
        issue(32'd1, 32'd1, 1'b0);
        step();
        issue(32'd2, 32'd2, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("mid_inflight2", inflight, 2);
        resetn = 1'b0;
        step();
        chk("mid_cmd_ready", cmd_ready, 0);
        chk("mid_alu_valid", alu_valid, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_op", alu_op, 0);
        chk("mid_inflight", inflight, 0);
        chk("mid_stray", stray_err, 0);
        step();
        chk("mid_res_valid", res_valid, 0);
        chk("mid_res_data", res_data, 0);
        q.delete();
        resetn = 1'b1;
        step();
        chk("post_stray", stray_err, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_res_valid", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
